// File: rtl/tpx3_status_led_pkg.sv
// Shared definitions for the Timepix3 status/indicator controller:
// link FSM state encodings and the counter width helper.
package tpx3_status_led_pkg;

    // Link qualifier FSM state type and encodings.
    typedef logic [1:0] link_state_t;

    localparam link_state_t LINK_DOWN    = 2'd0;
    localparam link_state_t LINK_QUALIFY = 2'd1;
    localparam link_state_t LINK_UP      = 2'd2;

    // Bits needed for a counter that must hold values 0..max_value.
    // Never returns 0, so degenerate parameters still give a legal vector.
    function automatic int cnt_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/tpx3_link_qualifier.sv
// One Timepix3 link: synchronises RX_READY, debounces it into a link-up
// flag, stretches data activity for the LED and keeps the sticky loss flag.
module tpx3_link_qualifier
    import tpx3_status_led_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 100,
    parameter int STRETCH_TICKS  = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_ready,     // asynchronous to clk
    input  logic activity,     // synchronous strobe or level
    input  logic tick,         // one-cycle time base pulse
    input  logic blink_phase,  // shared blink toggle
    input  logic clear_err,    // clears the sticky loss flag
    output logic linkup,
    output logic ch_led,
    output logic loss
);

    localparam int QW = cnt_width(DEBOUNCE_TICKS);
    localparam int SW = cnt_width(STRETCH_TICKS);

    localparam logic [QW-1:0] QUAL_LAST    = QW'(DEBOUNCE_TICKS - 1);
    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_TICKS);

    logic          rx_meta_q;
    logic          rx_sync_q;

    link_state_t   state_q,     state_d;
    logic [QW-1:0] qual_cnt_q,  qual_cnt_d;
    logic          linkup_q,    linkup_d;
    logic          loss_q,      loss_d;
    logic [SW-1:0] stretch_q,   stretch_d;
    logic          ch_led_q,    ch_led_d;

    // Two-flop synchroniser bringing RX_READY into the clk domain.
    // NOTE: sequential state is always written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b0;
            rx_sync_q <= 1'b0;
        end else begin
            rx_meta_q <= rx_ready;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Link FSM: qualify a stable ready for DEBOUNCE_TICKS ticks, flag drops from UP.
    // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        qual_cnt_d = qual_cnt_q;
        loss_d     = loss_q;

        if (clear_err) begin
            loss_d = 1'b0;
        end

        case (state_q)
            LINK_DOWN: begin
                if (rx_sync_q) begin
                    state_d    = LINK_QUALIFY;
                    qual_cnt_d = '0;
                end
            end
            LINK_QUALIFY: begin
                // A drop is checked first so it always beats a coincident tick.
                if (!rx_sync_q) begin
                    state_d = LINK_DOWN;
                end else if (tick) begin
                    if (qual_cnt_q == QUAL_LAST) begin
                        state_d = LINK_UP;
                    end
                    qual_cnt_d = qual_cnt_q + QW'(1);
                end
            end
            LINK_UP: begin
                if (!rx_sync_q) begin
                    state_d = LINK_DOWN;
                    // Written after the clear so a same-cycle loss stays visible.
                    loss_d  = 1'b1;
                end
            end
            default: begin
                state_d = LINK_DOWN;
            end
        endcase
    end

    // LINKUP follows the next state so it changes on the same edge as the FSM.
    always_comb begin
        linkup_d = (state_d == LINK_UP);
    end

    // Activity stretch: reload on every strobe, count down on ticks until empty.
    always_comb begin
        stretch_d = stretch_q;
        if (activity) begin
            stretch_d = STRETCH_LOAD;
        end else if (tick && (stretch_q != '0)) begin
            stretch_d = stretch_q - SW'(1);
        end
    end

    // Channel LED: solid while up and idle, blinking while recent activity is stretched.
    always_comb begin
        ch_led_d = (state_q == LINK_UP) && ((stretch_q != '0) ? blink_phase : 1'b1);
    end

    // State registers for FSM, flags, stretch counter and LED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LINK_DOWN;
            qual_cnt_q <= '0;
            linkup_q   <= 1'b0;
            loss_q     <= 1'b0;
            stretch_q  <= '0;
            ch_led_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            qual_cnt_q <= qual_cnt_d;
            linkup_q   <= linkup_d;
            loss_q     <= loss_d;
            stretch_q  <= stretch_d;
            ch_led_q   <= ch_led_d;
        end
    end

    assign linkup = linkup_q;
    assign ch_led = ch_led_q;
    assign loss   = loss_q;

endmodule

// File: rtl/tpx3_status_led.sv
// Status/indicator controller for multi-chip Timepix3 readout boards:
// shared time base, blink and heartbeat generators, Ethernet LED
// synchroniser, and one link qualifier per channel.
module tpx3_status_led
    import tpx3_status_led_pkg::*;
#(
    parameter int CHANNELS       = 1,
    parameter int TICK_DIV       = 40000,
    parameter int DEBOUNCE_TICKS = 100,
    parameter int STRETCH_TICKS  = 50,
    parameter int BLINK_TICKS    = 64,
    parameter int HB_TICKS       = 500
) (
    input  logic                BUS_CLK,
    input  logic                BUS_RST,
    input  logic [CHANNELS-1:0] RX_READY,
    input  logic                ETH_STATUS_OK,
    input  logic [CHANNELS-1:0] ACTIVITY,
    input  logic                CLEAR_ERR,
    output logic [CHANNELS-1:0] LINKUP,
    output logic [CHANNELS-1:0] CH_LED,
    output logic                ETH_LED,
    output logic                HB_LED,
    output logic                ERR_LED,
    output logic [CHANNELS-1:0] LOSS
);

    localparam int PW = cnt_width(TICK_DIV);
    localparam int BW = cnt_width(BLINK_TICKS);
    localparam int HW = cnt_width(HB_TICKS);

    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [HW-1:0] HB_LAST    = HW'(HB_TICKS - 1);

    logic          eth_meta_q;
    logic          eth_sync_q;

    logic [PW-1:0] presc_q,       presc_d;
    logic          tick;

    logic [BW-1:0] blink_cnt_q,   blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [HW-1:0] hb_cnt_q,      hb_cnt_d;
    logic          hb_q,          hb_d;

    // Two-flop synchroniser for the Ethernet link status; the second flop drives the LED.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            eth_meta_q <= 1'b0;
            eth_sync_q <= 1'b0;
        end else begin
            eth_meta_q <= ETH_STATUS_OK;
            eth_sync_q <= eth_meta_q;
        end
    end

    // Prescaler: wrap at TICK_DIV-1 and pulse tick on the terminal count.
    always_comb begin
        tick    = (presc_q == TICK_LAST);
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Blink phase: toggle once every BLINK_TICKS ticks.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // Heartbeat: toggle once every HB_TICKS ticks, regardless of link state.
    always_comb begin
        hb_cnt_d = hb_cnt_q;
        hb_d     = hb_q;
        if (tick) begin
            if (hb_cnt_q == HB_LAST) begin
                hb_cnt_d = '0;
                hb_d     = ~hb_q;
            end else begin
                hb_cnt_d = hb_cnt_q + HW'(1);
            end
        end
    end

    // Time base registers shared by all channels.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            presc_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            hb_cnt_q      <= '0;
            hb_q          <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            hb_cnt_q      <= hb_cnt_d;
            hb_q          <= hb_d;
        end
    end

    // One qualifier per link.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_link
        tpx3_link_qualifier #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .STRETCH_TICKS  (STRETCH_TICKS)
        ) u_link (
            .clk         (BUS_CLK),
            .rst         (BUS_RST),
            .rx_ready    (RX_READY[i]),
            .activity    (ACTIVITY[i]),
            .tick        (tick),
            .blink_phase (blink_phase_q),
            .clear_err   (CLEAR_ERR),
            .linkup      (LINKUP[i]),
            .ch_led      (CH_LED[i]),
            .loss        (LOSS[i])
        );
    end

    assign ETH_LED = eth_sync_q;
    assign HB_LED  = hb_q;
    assign ERR_LED = |LOSS;

endmodule

// File: tb/tb_tpx3_status_led.sv
// Directed bench for tpx3_status_led with a short time base: reset,
// qualification latency, glitch restart, loss/clear, set-wins-over-clear,
// activity blink and heartbeat, and reset in the middle of operation.
module tb_tpx3_status_led;

    localparam int CHANNELS       = 4;
    localparam int TICK_DIV       = 4;
    localparam int DEBOUNCE_TICKS = 3;
    localparam int STRETCH_TICKS  = 5;
    localparam int BLINK_TICKS    = 2;
    localparam int HB_TICKS       = 10;

    logic                BUS_CLK = 1'b0;
    logic                BUS_RST = 1'b1;
    logic [CHANNELS-1:0] RX_READY = '0;
    logic                ETH_STATUS_OK = 1'b0;
    logic [CHANNELS-1:0] ACTIVITY = '0;
    logic                CLEAR_ERR = 1'b0;
    logic [CHANNELS-1:0] LINKUP;
    logic [CHANNELS-1:0] CH_LED;
    logic                ETH_LED;
    logic                HB_LED;
    logic                ERR_LED;
    logic [CHANNELS-1:0] LOSS;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc;

    tpx3_status_led #(
        .CHANNELS       (CHANNELS),
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .STRETCH_TICKS  (STRETCH_TICKS),
        .BLINK_TICKS    (BLINK_TICKS),
        .HB_TICKS       (HB_TICKS)
    ) dut (
        .BUS_CLK       (BUS_CLK),
        .BUS_RST       (BUS_RST),
        .RX_READY      (RX_READY),
        .ETH_STATUS_OK (ETH_STATUS_OK),
        .ACTIVITY      (ACTIVITY),
        .CLEAR_ERR     (CLEAR_ERR),
        .LINKUP        (LINKUP),
        .CH_LED        (CH_LED),
        .ETH_LED       (ETH_LED),
        .HB_LED        (HB_LED),
        .ERR_LED       (ERR_LED),
        .LOSS          (LOSS)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    // Rising edges since the last reset release; the time base phase is a pure function of it.
    always @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge BUS_CLK);
    endtask

    // Ticks take effect on edges that are multiples of TICK_DIV.
    function automatic logic blink_at(input int n);
        return ((n / (TICK_DIV * BLINK_TICKS)) % 2) == 1;
    endfunction

    function automatic logic hb_at(input int n);
        return ((n / (TICK_DIV * HB_TICKS)) % 2) == 1;
    endfunction

    // Stretch count after edge n, given it was loaded on edge load_edge.
    function automatic int stretch_at(input int n, input int load_edge);
        int dec;
        if (n < load_edge) return 0;
        dec = n / TICK_DIV - load_edge / TICK_DIV;
        return (dec >= STRETCH_TICKS) ? 0 : STRETCH_TICKS - dec;
    endfunction

    // Edges from RX_READY rising (driven after edge e0) to LINKUP rising:
    // QUALIFY is entered at edge e0+3, the first counted tick lands on the
    // first multiple of TICK_DIV at or after e0+4, then DEBOUNCE_TICKS-1 more.
    function automatic int qual_latency(input int e0);
        int m0;
        m0 = ((e0 + 4 + TICK_DIV - 1) / TICK_DIV) * TICK_DIV;
        return m0 + (DEBOUNCE_TICKS - 1) * TICK_DIV - e0;
    endfunction

    task automatic wait_linkup(input int ch, input int max_cyc, output int lat);
        lat = 0;
        while (LINKUP[ch] !== 1'b1 && lat < max_cyc) begin
            @(negedge BUS_CLK);
            lat++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int lat;
        int load_edge;
        logic exp_led;

        // Reset state.
        step();
        step();
        check("rst_linkup",  LINKUP,  4'b0000);
        check("rst_ch_led",  CH_LED,  4'b0000);
        check("rst_loss",    LOSS,    4'b0000);
        check("rst_eth_led", ETH_LED, 1'b0);
        check("rst_hb_led",  HB_LED,  1'b0);
        check("rst_err_led", ERR_LED, 1'b0);

        // Release reset and raise Ethernet status: two-flop delay.
        BUS_RST = 1'b0;
        ETH_STATUS_OK = 1'b1;
        step();
        check("eth_after_1", ETH_LED, 1'b0);
        step();
        check("eth_after_2", ETH_LED, 1'b1);

        // Qualify channel 2.
        e0 = cyc;
        RX_READY[2] = 1'b1;
        wait_linkup(2, 30, lat);
        check("qual2_latency", lat, qual_latency(e0));
        check("qual2_window", (lat >= 11 && lat <= 15), 1'b1);
        check("qual2_others", LINKUP, 4'b0100);
        step();
        check("qual2_ch_led", CH_LED, 4'b0100);
        check("qual2_loss", LOSS, 4'b0000);

        // Channel 1: glitch during QUALIFY restarts qualification.
        RX_READY[1] = 1'b1;
        repeat (6) step();
        check("glitch_pre", LINKUP[1], 1'b0);
        RX_READY[1] = 1'b0;
        step();
        step();
        check("glitch_mid", LINKUP[1], 1'b0);
        e0 = cyc;
        RX_READY[1] = 1'b1;
        wait_linkup(1, 30, lat);
        check("glitch_requal_latency", lat, qual_latency(e0));
        check("glitch_loss", LOSS, 4'b0000);
        check("glitch_err", ERR_LED, 1'b0);

        // Channel 0: qualify, then lose the link.
        e0 = cyc;
        RX_READY[0] = 1'b1;
        wait_linkup(0, 30, lat);
        check("qual0_latency", lat, qual_latency(e0));
        step();
        RX_READY[0] = 1'b0;
        step();
        check("loss0_edge1", LINKUP[0], 1'b1);
        step();
        check("loss0_edge2", LINKUP[0], 1'b1);
        check("loss0_edge2_loss", LOSS, 4'b0000);
        step();
        check("loss0_edge3", LINKUP, 4'b0110);
        check("loss0_flag", LOSS, 4'b0001);
        check("loss0_err", ERR_LED, 1'b1);
        step();
        check("loss0_ch_led", CH_LED, 4'b0110);
        CLEAR_ERR = 1'b1;
        step();
        CLEAR_ERR = 1'b0;
        check("clear_err_led", ERR_LED, 1'b0);
        check("clear_loss", LOSS, 4'b0000);

        // Channel 3: loss in the same cycle as CLEAR_ERR keeps the flag.
        e0 = cyc;
        RX_READY[3] = 1'b1;
        wait_linkup(3, 30, lat);
        check("qual3_latency", lat, qual_latency(e0));
        check("qual3_linkup", LINKUP, 4'b1110);
        step();
        RX_READY[3] = 1'b0;
        step();
        step();
        CLEAR_ERR = 1'b1;
        step();
        CLEAR_ERR = 1'b0;
        check("simul_linkup", LINKUP, 4'b0110);
        check("simul_loss", LOSS, 4'b1000);
        check("simul_err", ERR_LED, 1'b1);
        repeat (3) step();
        check("simul_loss_sticky", LOSS, 4'b1000);

        // Activity on channel 2: blink for STRETCH_TICKS ticks, then solid again.
        step();
        ACTIVITY[2] = 1'b1;
        step();
        ACTIVITY[2] = 1'b0;
        load_edge = cyc;
        for (int k = 0; k < 48; k++) begin
            exp_led = (stretch_at(cyc - 1, load_edge) != 0) ? blink_at(cyc - 1) : 1'b1;
            check("act_ch_led2", CH_LED[2], exp_led);
            check("act_ch_led1", CH_LED[1], 1'b1);
            check("hb_led", HB_LED, hb_at(cyc));
            step();
        end
        check("act_solid", CH_LED, 4'b0110);

        // Heartbeat across a full period.
        for (int k = 0; k < 50; k++) begin
            check("hb_led_run", HB_LED, hb_at(cyc));
            step();
        end

        // Reset mid-operation: outputs drop asynchronously, then full re-qualify.
        #2 BUS_RST = 1'b1;
        #1;
        check("midrst_linkup",  LINKUP,  4'b0000);
        check("midrst_ch_led",  CH_LED,  4'b0000);
        check("midrst_loss",    LOSS,    4'b0000);
        check("midrst_err",     ERR_LED, 1'b0);
        check("midrst_eth",     ETH_LED, 1'b0);
        check("midrst_hb",      HB_LED,  1'b0);
        step();
        BUS_RST = 1'b0;
        for (int k = 1; k <= qual_latency(0) - 1; k++) begin
            step();
            check("midrst_hold", LINKUP, 4'b0000);
        end
        step();
        check("midrst_requal", LINKUP, 4'b0110);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
